ni_target_rsp_packetizer: RTL
=============================

# ni_target_rsp_packetizer

Response packetizer for an NI target. It takes OCP-style response beats from the attached slave. It looks up the return route for each packet's source ID in the per-target routing LUT (`lut_address` out, `lut_path` in; the LUT is combinational and instantiated alongside this block). It then emits a head flit followed by one flit per data beat into the switch input port under credit-based flow control.

## Interface
Parameters:
- `SOURCEWD`, 4, source-ID width (matches `SOURCEWD` from `noc_parameters.v`)
- `PATHWD`, 7, route field width (first hop in LSBs)
- `DATAWD`, 32, response data width
- `FLITWD`, 80, flit width; must be ≥ 2+PATHWD+SOURCEWD+2 and ≥ 2+DATAWD
- `NUM_CREDITS`, 4, downstream buffer depth in flits

Ports (one clock; reset is synchronous, active-low):
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous active-low reset
- `rsp_valid`  in  1  response beat valid
- `rsp_ready`  out  1  response beat accepted when `rsp_valid && rsp_ready`
- `rsp_source`  in  SOURCEWD  ID of the initiator owed this response; sampled on the first beat only
- `rsp_code`  in  2  OCP SResp; sampled on the first beat only
- `rsp_data`  in  DATAWD  beat data
- `rsp_last`  in  1  final beat of the response
- `lut_address`  out  SOURCEWD  routing-LUT index
- `lut_path`  in  PATHWD  routing-LUT result
- `flit_out`  out  FLITWD  flit to switch
- `flit_valid`  out  1  flit present this cycle
- `credit_in`  in  1  one downstream buffer slot freed

## Operation
- Flit type `flit_out[1:0]`: 01 head, 00 body, 10 tail.
- Head flit layout:
  - `[2+:PATHWD]` = path
  - `[2+PATHWD+:SOURCEWD]` = this NI's request source ID echoed back
  - next 2 bits = `rsp_code`
  - remaining bits 0
- Body/tail flit layout: `[2+:DATAWD]` = data; remaining bits 0.
- Packet = head + N data flits (N ≥ 1). The beat with `rsp_last` becomes the tail flit.
- FSM states and transitions:
  - IDLE:
    - `rsp_ready`=0.
    - If `rsp_valid`: capture `rsp_source` into `src_q` and `rsp_code` into `code_q`; go to HEAD.
    - The beat is not consumed.
  - HEAD:
    - `lut_address`=`src_q`.
    - If `credits>0`: register head flit built from `lut_path`; go to BODY.
    - Otherwise stay.
  - BODY:
    - `rsp_ready = (credits>0)`.
    - On accept, register a body flit, or a tail flit if `rsp_last`.
    - Tail goes to IDLE; else stay.
- `lut_address` equals `src_q` in all states, so it is stable during HEAD.
- Credit counter, width `$clog2(NUM_CREDITS+1)`, reset to `NUM_CREDITS`:
  - Decrements on each flit issued and increments on `credit_in`.
  - Both in the same cycle: no change.
  - `credit_in` at `NUM_CREDITS` with no send saturates (ignored).
- A flit is issued only when `credits>0`, so it never goes negative.
- `rsp_source`/`rsp_code` changes on later beats are ignored.

## Timing
- Reset values: `flit_valid`=0, `flit_out`=0, `rsp_ready`=0, `lut_address`=0, state IDLE, credits=`NUM_CREDITS`, `src_q`/`code_q`=0.
- All outputs except `rsp_ready` are registered. `rsp_ready` is combinational from state and credits only, never from `rsp_valid`.
- `flit_valid` is high for exactly one cycle per flit.
- No back-pressure on `flit_out`: the credit check is the only flow control.
- Latency (`rsp_valid` rising in IDLE at cycle 0, credits available):
  - State HEAD in cycle 1.
  - Head flit valid in cycle 2.
  - First data beat accepted in cycle 2 and its flit valid in cycle 3.
- Throughput: 1 flit/cycle in BODY while credits > 0. Per-packet overhead is 2 cycles (IDLE→HEAD plus the head flit).
- Back-to-back packets: tail accept returns to IDLE. If `rsp_valid` is already high, HEAD is entered the next cycle.
- Reset asserted mid-packet:
  - At the next edge: IDLE, credits restored, `flit_valid`=0.
  - The partial packet is dropped; the switch is reset in the same domain.

## Test plan
- Single-beat read, source 4'h6, `lut_path` 7'b0000010, code 2'b01, data 32'hDEADBEEF:
  - Cycle 2: head, `flit_out[8:2]`=0000010, source field 6, code 01.
  - Cycle 3: tail, data DEADBEEF.
  - Credits 4→2.
- 4-beat burst, NUM_CREDITS=4, no `credit_in`:
  - Head + 3 body flits issued.
  - `rsp_ready` drops with credits=0; 4th beat stalls.
  - One `credit_in` pulse → tail issued the following cycle.
- Simultaneous `credit_in` and flit send at credits=1: counter stays 1 and the next flit is issued without a gap.
- Spurious `credit_in` at credits=`NUM_CREDITS`: counter stays 4. Then a 5-flit packet (head + 4 beats) stalls exactly before the tail.
- Two back-to-back packets, sources 4'hd then 4'h9 (paths 0000011, 0011100):
  - Each head carries its own path.
  - `lut_address` switches only after the first tail.
- `reset_n` low for one cycle after the head flit of a 3-beat packet:
  - Next cycle: `flit_valid`=0, credits=4, state IDLE.
  - A new packet then starts cleanly with a head flit.

Source files
------------

// File: rtl/ni_target_rsp_packetizer.sv
// Response packetizer for an NI target: turns slave response beats into a
// head flit (route, source, response code) followed by one flit per data
// beat, under credit-based flow control towards the switch input port.
module ni_target_rsp_packetizer #(
  parameter int SOURCEWD    = 4,
  parameter int PATHWD      = 7,
  parameter int DATAWD      = 32,
  parameter int FLITWD      = 80,
  parameter int NUM_CREDITS = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rsp_valid,
  output logic                rsp_ready,
  input  logic [SOURCEWD-1:0] rsp_source,
  input  logic [1:0]          rsp_code,
  input  logic [DATAWD-1:0]   rsp_data,
  input  logic                rsp_last,
  output logic [SOURCEWD-1:0] lut_address,
  input  logic [PATHWD-1:0]   lut_path,
  output logic [FLITWD-1:0]   flit_out,
  output logic                flit_valid,
  input  logic                credit_in
);

  localparam int CRW = $clog2(NUM_CREDITS + 1);
  localparam logic [CRW-1:0] CR_MAX = CRW'(NUM_CREDITS);
  localparam logic [CRW-1:0] CR_ONE = CRW'(1);

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t              state_q;
  logic [CRW-1:0]      credits_q;
  logic [CRW-1:0]      credits_d;
  logic [SOURCEWD-1:0] src_q;
  logic [1:0]          code_q;
  logic [FLITWD-1:0]   flit_q;
  logic                flit_valid_q;

  logic                have_credit;
  logic                send_head;
  logic                send_body;
  logic                flit_send;
  logic [FLITWD-1:0]   head_flit;
  logic [FLITWD-1:0]   data_flit;

  // A flit may only leave when a downstream slot is known to be free.
  assign have_credit = (credits_q != '0);
  // Ready depends on state and credits only, never on rsp_valid.
  assign rsp_ready   = (state_q == BODY) && have_credit;
  assign send_head   = (state_q == HEAD) && have_credit;
  assign send_body   = rsp_valid && rsp_ready;
  assign flit_send   = send_head || send_body;

  // The captured source indexes the routing LUT, so the path is stable in HEAD.
  assign lut_address = src_q;
  assign flit_out    = flit_q;
  assign flit_valid  = flit_valid_q;

  // Head flit: type, route from the LUT, echoed source ID and response code.
  always_comb begin
    head_flit                            = '0;
    head_flit[1:0]                       = TYPE_HEAD;
    head_flit[2 +: PATHWD]               = lut_path;
    head_flit[2+PATHWD +: SOURCEWD]      = src_q;
    head_flit[2+PATHWD+SOURCEWD +: 2]    = code_q;
  end

  // Data flit: the beat carrying rsp_last closes the packet as a tail.
  always_comb begin
    data_flit              = '0;
    data_flit[1:0]         = rsp_last ? TYPE_TAIL : TYPE_BODY;
    data_flit[2 +: DATAWD] = rsp_data;
  end

  // Credit bookkeeping: a send and a returned credit together cancel out;
  // a returned credit with the counter already full is dropped.
  always_comb begin
    credits_d = credits_q;
    if (flit_send && !credit_in) begin
      credits_d = credits_q - CR_ONE;
    end else if (!flit_send && credit_in && (credits_q != CR_MAX)) begin
      credits_d = credits_q + CR_ONE;
    end
  end

  // Packet FSM with registered flit outputs and credit counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      credits_q    <= CR_MAX;
      src_q        <= '0;
      code_q       <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      flit_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The first beat is only peeked at here; BODY consumes it.
          if (rsp_valid) begin
            src_q   <= rsp_source;
            code_q  <= rsp_code;
            state_q <= HEAD;
          end
        end
        HEAD: begin
          if (send_head) begin
            flit_q       <= head_flit;
            flit_valid_q <= 1'b1;
            state_q      <= BODY;
          end
        end
        BODY: begin
          if (send_body) begin
            flit_q       <= data_flit;
            flit_valid_q <= 1'b1;
            if (rsp_last) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
